// File: rtl/axi_stream_rr_arbiter.sv
// Packet-aware round-robin merge of NUM_PORTS valid/ready streams onto one forward-registered output.
// A grant is held from the first beat until the granted port's last beat is accepted.
module axi_stream_rr_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PORTS-1:0]            s_axi_valid,
   output logic [NUM_PORTS-1:0]            s_axi_ready,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axi_data,
   input  logic [NUM_PORTS-1:0]            s_axi_last,
   output logic                            m_axi_valid,
   input  logic                            m_axi_ready,
   output logic [DATA_WIDTH-1:0]           m_axi_data,
   output logic                            m_axi_last,
   output logic [ID_WIDTH-1:0]             m_axi_port,
   output logic                            busy
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                  state, state_nxt;
   logic [ID_WIDTH-1:0]     grant, grant_nxt;
   logic [ID_WIDTH-1:0]     rr_ptr, rr_ptr_nxt;
   logic [ID_WIDTH-1:0]     pick;
   logic [ID_WIDTH:0]       pick_sum;
   logic [2*NUM_PORTS-1:0]  valid_dbl;
   logic [NUM_PORTS-1:0]    valid_rot;
   logic                    out_free;
   logic                    accept;
   logic                    sel_last;
   logic [DATA_WIDTH-1:0]   sel_data;

   assign out_free = ~m_axi_valid | m_axi_ready;
   assign busy     = (state == BUSY);

   always_comb begin
      sel_data    = '0;
      sel_last    = 1'b0;
      s_axi_ready = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant == ID_WIDTH'(i)) begin
            sel_data       = s_axi_data[i*DATA_WIDTH +: DATA_WIDTH];
            sel_last       = s_axi_last[i];
            // held low while reset is asserted so no beat is taken mid-reset
            s_axi_ready[i] = busy & out_free & ~reset;
         end
      end
   end

   assign accept = |(s_axi_valid & s_axi_ready);

   // rotate valids so bit 0 is the port at rr_ptr; lowest set bit wins
   assign valid_dbl = {s_axi_valid, s_axi_valid} >> rr_ptr;
   assign valid_rot = valid_dbl[NUM_PORTS-1:0];

   always_comb begin
      pick_sum = {1'b0, rr_ptr};
      for (int j = NUM_PORTS - 1; j >= 0; j--) begin
         if (valid_rot[j]) begin
            pick_sum = {1'b0, rr_ptr} + (ID_WIDTH+1)'(j);
         end
      end
      if (pick_sum >= (ID_WIDTH+1)'(NUM_PORTS)) begin
         pick_sum = pick_sum - (ID_WIDTH+1)'(NUM_PORTS);
      end
      pick = pick_sum[ID_WIDTH-1:0];
   end

   always_comb begin
      state_nxt  = state;
      grant_nxt  = grant;
      rr_ptr_nxt = rr_ptr;
      case (state)
         IDLE: begin
            if (|s_axi_valid) begin
               state_nxt = BUSY;
               grant_nxt = pick;
            end
         end
         BUSY: begin
            if (accept && sel_last) begin
               state_nxt  = IDLE;
               rr_ptr_nxt = (grant == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         grant  <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_nxt;
         grant  <= grant_nxt;
         rr_ptr <= rr_ptr_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_axi_valid <= 1'b0;
         m_axi_data  <= '0;
         m_axi_last  <= 1'b0;
         m_axi_port  <= '0;
      end else if (out_free) begin
         if (accept) begin
            m_axi_valid <= 1'b1;
            m_axi_data  <= sel_data;
            m_axi_last  <= sel_last;
            m_axi_port  <= grant;
         end else begin
            m_axi_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Directed and randomized checks of axi_stream_rr_arbiter against a packet-level round-robin model.
module tb_axi_stream_rr_arbiter;

   localparam int NP = 4;
   localparam int DW = 32;
   localparam int IW = 2;

   typedef struct packed {
      logic [IW-1:0] port;
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic             clk = 1'b0;
   logic             reset;
   logic [NP-1:0]    s_valid, s_ready, s_last;
   logic [NP*DW-1:0] s_data;
   logic             m_valid, m_ready, m_last, busy;
   logic [DW-1:0]    m_data;
   logic [IW-1:0]    m_port;

   int vectors     = 0;
   int miscompares = 0;

   logic [DW:0] src_mem [NP][64];
   int          src_rd  [NP];
   int          src_wr  [NP];
   logic [NP-1:0] mid;
   int          m_ptr;
   beat_t       exp_q[$];
   int          pkt_order[$];
   int          last_cyc[$];

   always #5 clk = ~clk;

   axi_stream_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
      .clk(clk), .reset(reset),
      .s_axi_valid(s_valid), .s_axi_ready(s_ready), .s_axi_data(s_data), .s_axi_last(s_last),
      .m_axi_valid(m_valid), .m_axi_ready(m_ready), .m_axi_data(m_data), .m_axi_last(m_last),
      .m_axi_port(m_port), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int p, input logic v, input logic [DW-1:0] d, input logic l);
      s_valid[p]           = v;
      s_data[p*DW +: DW]   = d;
      s_last[p]            = l;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      s_valid = '0;
      s_last  = '0;
      s_data  = '0;
      m_ready = 1'b1;
      step();
      step();
      reset = 1'b0;
      m_ptr = 0;
   endtask

   task automatic clear_src();
      for (int i = 0; i < NP; i++) begin
         src_rd[i] = 0;
         src_wr[i] = 0;
      end
   endtask

   task automatic add_pkt(input int p, input int len, input logic [DW-1:0] base);
      for (int b = 0; b < len; b++) begin
         src_mem[p][src_wr[p]] = {(b == len - 1), base + DW'(b)};
         src_wr[p]++;
      end
   endtask

   // Packet-level round robin: next packet comes from the first port at or after the pointer that still has one.
   task automatic build_model();
      int    rd [NP];
      int    p;
      int    c;
      logic [DW:0] b;
      beat_t nb;
      for (int i = 0; i < NP; i++) rd[i] = src_rd[i];
      exp_q.delete();
      forever begin
         p = -1;
         for (int k = 0; k < NP; k++) begin
            c = (m_ptr + k) % NP;
            if (p < 0 && rd[c] < src_wr[c]) p = c;
         end
         if (p < 0) break;
         do begin
            b = src_mem[p][rd[p]];
            rd[p]++;
            nb.port = IW'(p);
            nb.data = b[DW-1:0];
            nb.last = b[DW];
            exp_q.push_back(nb);
         end while (!b[DW]);
         m_ptr = (p + 1) % NP;
      end
   endtask

   // Every port with queued packets holds valid high at packet starts; gaps only mid-packet.
   task automatic run_traffic(input int ready_pct, input int gap_pct, input logic [63:0] stall_mask,
                              input int max_cycles);
      int            cyc;
      logic [NP-1:0] acc;
      logic          hold_prev;
      logic [DW-1:0] held_data;
      logic          open;
      logic [IW-1:0] open_port;
      beat_t         e;
      build_model();
      cyc       = 0;
      hold_prev = 1'b0;
      held_data = '0;
      open      = 1'b0;
      open_port = '0;
      mid       = '0;
      pkt_order.delete();
      last_cyc.delete();
      while (exp_q.size() > 0 && cyc < max_cycles) begin
         for (int i = 0; i < NP; i++) begin
            if (src_rd[i] < src_wr[i]) begin
               s_valid[i] = mid[i] ? ($urandom_range(99) >= gap_pct) : 1'b1;
               {s_last[i], s_data[i*DW +: DW]} = src_mem[i][src_rd[i]];
            end else begin
               s_valid[i] = 1'b0;
               s_last[i]  = 1'b0;
            end
         end
         if (cyc < 64 && stall_mask[cyc[5:0]]) m_ready = 1'b0;
         else m_ready = ($urandom_range(99) < ready_pct);
         @(negedge clk);
         acc = s_valid & s_ready;
         chk("ready_onehot", ($countones(s_ready) <= 1), 1);
         if (hold_prev) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, held_data);
         end
         if (m_valid && !m_ready) chk("stall_no_ready", s_ready, 0);
         if (m_valid && m_ready) begin
            e = exp_q.pop_front();
            chk("out_data", m_data, e.data);
            chk("out_port", m_port, e.port);
            chk("out_last", m_last, e.last);
            if (open) chk("no_interleave", m_port, open_port);
            open      = !m_last;
            open_port = m_port;
            if (m_last) begin
               pkt_order.push_back(int'(m_port));
               last_cyc.push_back(cyc);
            end
         end
         hold_prev = m_valid && !m_ready;
         held_data = m_data;
         @(posedge clk);
         for (int i = 0; i < NP; i++) begin
            if (acc[i]) begin
               mid[i] = !src_mem[i][src_rd[i]][DW];
               src_rd[i]++;
            end
         end
         #1;
         cyc++;
      end
      chk("traffic_done", (exp_q.size() == 0), 1);
      for (int i = 0; i < NP; i++) chk("src_drained", src_rd[i], src_wr[i]);
      s_valid = '0;
      s_last  = '0;
      m_ready = 1'b1;
   endtask

   initial begin
      int exp_fair [6] = '{0, 1, 2, 3, 0, 1};

      // reset values, during and just after reset
      reset   = 1'b1;
      s_valid = '0;
      s_last  = '0;
      s_data  = '0;
      m_ready = 1'b1;
      step();
      step();
      @(negedge clk);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_port", m_port, 0);
      chk("rst_busy", busy, 0);
      chk("rst_s_ready", s_ready, 0);
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_s_ready", s_ready, 0);
      step();

      // single port 2, three beats
      drive(2, 1'b1, 32'hA0, 1'b0);
      @(negedge clk);
      chk("sp_idle_busy", busy, 0);
      chk("sp_idle_ready", s_ready, 0);
      step();
      @(negedge clk);
      chk("sp_grant_busy", busy, 1);
      chk("sp_grant_ready", s_ready, 4'b0100);
      chk("sp_grant_mvalid", m_valid, 0);
      step();
      drive(2, 1'b1, 32'hA1, 1'b0);
      @(negedge clk);
      chk("sp_a0_valid", m_valid, 1);
      chk("sp_a0_data", m_data, 32'hA0);
      chk("sp_a0_port", m_port, 2);
      chk("sp_a0_last", m_last, 0);
      step();
      drive(2, 1'b1, 32'hA2, 1'b1);
      @(negedge clk);
      chk("sp_a1_data", m_data, 32'hA1);
      chk("sp_a1_last", m_last, 0);
      step();
      drive(2, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("sp_a2_data", m_data, 32'hA2);
      chk("sp_a2_last", m_last, 1);
      chk("sp_a2_busy", busy, 0);
      step();
      @(negedge clk);
      chk("sp_drain_valid", m_valid, 0);
      step();

      // wrap: pointer sits at 3 after serving port 2
      m_ptr = 3;
      clear_src();
      add_pkt(0, 2, 32'h0100);
      add_pkt(3, 2, 32'h0300);
      run_traffic(100, 0, 64'h0, 200);
      chk("wrap_count", pkt_order.size(), 2);
      if (pkt_order.size() == 2) begin
         chk("wrap_first", pkt_order[0], 3);
         chk("wrap_second", pkt_order[1], 0);
      end

      // fairness from reset: two 2-beat packets per port
      do_reset();
      clear_src();
      for (int p = 0; p < NP; p++) begin
         add_pkt(p, 2, 32'h1000 * (p + 1));
         add_pkt(p, 2, 32'h1000 * (p + 1) + 32'h10);
      end
      run_traffic(100, 0, 64'h0, 200);
      chk("fair_count", pkt_order.size(), 8);
      for (int k = 0; k < 6 && k < pkt_order.size(); k++) chk("fair_order", pkt_order[k], exp_fair[k]);
      for (int k = 1; k < last_cyc.size(); k++) chk("fair_spacing", last_cyc[k] - last_cyc[k-1], 3);

      // backpressure: downstream stalls cycles 2-5 of a 4-beat packet
      clear_src();
      add_pkt(1, 4, 32'hB000);
      run_traffic(100, 0, 64'h3C, 200);
      chk("bp_count", pkt_order.size(), 1);

      // packet lock: port 0 drops valid mid-packet while port 1 waits
      do_reset();
      drive(0, 1'b1, 32'hC0, 1'b0);
      drive(1, 1'b1, 32'hD0, 1'b1);
      step();
      @(negedge clk);
      chk("lock_grant", s_ready, 4'b0001);
      step();
      drive(0, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("lock_hold_ready", s_ready, 4'b0001);
         chk("lock_hold_busy", busy, 1);
         step();
      end
      drive(0, 1'b1, 32'hC1, 1'b1);
      @(negedge clk);
      chk("lock_last_ready", s_ready, 4'b0001);
      step();
      drive(0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("lock_idle_busy", busy, 0);
      chk("lock_c1_data", m_data, 32'hC1);
      chk("lock_c1_port", m_port, 0);
      step();
      @(negedge clk);
      chk("lock_next_grant", s_ready, 4'b0010);
      step();
      drive(1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("lock_d0_data", m_data, 32'hD0);
      chk("lock_d0_port", m_port, 1);
      chk("lock_d0_last", m_last, 1);
      step();

      // reset during beat 2 of 4 on port 3; pointer was 2 before reset
      drive(3, 1'b1, 32'hE0, 1'b0);
      step();
      @(negedge clk);
      chk("mr_grant", s_ready, 4'b1000);
      step();
      drive(3, 1'b1, 32'hE1, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      chk("mr_ready_during", s_ready, 0);
      step();
      reset = 1'b0;
      drive(1, 1'b1, 32'hF1, 1'b1);
      drive(3, 1'b1, 32'hF3, 1'b1);
      @(negedge clk);
      chk("mr_m_valid", m_valid, 0);
      chk("mr_busy", busy, 0);
      chk("mr_s_ready", s_ready, 0);
      step();
      @(negedge clk);
      chk("mr_fresh_grant", s_ready, 4'b0010);
      step();
      drive(1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("mr_f1_data", m_data, 32'hF1);
      step();
      @(negedge clk);
      chk("mr_second_grant", s_ready, 4'b1000);
      step();
      drive(3, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("mr_f3_data", m_data, 32'hF3);
      chk("mr_f3_port", m_port, 3);
      step();

      // randomized traffic: mid-packet gaps and random downstream stalls
      do_reset();
      for (int r = 0; r < 25; r++) begin
         clear_src();
         for (int p = 0; p < NP; p++) begin
            int npk;
            npk = $urandom_range(3);
            for (int k = 0; k < npk; k++) add_pkt(p, $urandom_range(5, 1), $urandom());
         end
         run_traffic(70, 30, 64'h0, 2000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
